// File: rtl/coso_calib_pkg.sv
// Shared definitions for the COSO TRNG calibration controller.
//   - coso_state_e : controller FSM states
//   - PARAM field placement for the two oscillator delay configurations
//   - in_window()  : inclusive range test used on samples and averages
package coso_calib_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_MEASURE = 3'd2,
    ST_EVAL    = 3'd3,
    ST_RUN     = 3'd4,
    ST_FAIL    = 3'd5
  } coso_state_e;

  localparam int CFG_A_LSB = 8;
  localparam int CFG_B_LSB = 0;
  localparam int CFG_W     = 8;

  // Both bounds are inclusive.
  function automatic logic in_window(input logic [7:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/coso_bit_packer.sv
// Packs single random bits into bytes and presents them on a valid/ready port.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   bit_in, bit_en     : one harvested bit, qualified by bit_en
//   clr                : drop partial bits (a byte already in OUT_DATA is kept)
//   OUT_DATA/OUT_VALID : packed byte and its valid flag
//   OUT_READY          : downstream accept
//   OVERFLOW           : sticky, set when a completed byte had nowhere to go
//
// Handshake: a byte transfers on every cycle where OUT_VALID=1 and OUT_READY=1.
// While OUT_VALID=1 and OUT_READY=0, OUT_DATA is held stable. OUT_VALID never
// depends combinationally on OUT_READY.
module coso_bit_packer (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_en,
  input  logic       clr,
  output logic [7:0] OUT_DATA,
  output logic       OUT_VALID,
  input  logic       OUT_READY,
  output logic       OVERFLOW
);

  logic [6:0] shreg;
  logic [2:0] nbits;
  logic       byte_done;
  logic [7:0] new_byte;

  // clr wins over a simultaneous bit so a recalibration never completes a byte.
  assign byte_done = bit_en && !clr && (nbits == 3'd7);
  // First bit received ends up in the MSB.
  assign new_byte  = {shreg, bit_in};

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg     <= '0;
      nbits     <= '0;
      OUT_DATA  <= '0;
      OUT_VALID <= 1'b0;
      OVERFLOW  <= 1'b0;
    end else begin
      if (clr) begin
        shreg <= '0;
        nbits <= '0;
      end else if (bit_en) begin
        shreg <= {shreg[5:0], bit_in};
        nbits <= nbits + 3'd1;  // wraps 7 -> 0 on byte completion
      end

      // The output slot is free if empty or being emptied this cycle.
      if (byte_done && (!OUT_VALID || OUT_READY)) begin
        OUT_DATA  <= new_byte;
        OUT_VALID <= 1'b1;
      end else if (OUT_READY) begin
        OUT_VALID <= 1'b0;
      end

      if (byte_done && OUT_VALID && !OUT_READY) begin
        OVERFLOW <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/coso_calib_ctrl.sv
// Closed-loop calibration controller for the configurable COSO TRNG unit.
// Sweeps the 16-bit candidate {cfg_a,cfg_b} until the averaged beat count lies
// inside [CNT_MIN, CNT_MAX], then harvests count LSBs as random bits, packing
// them into bytes. Recalibrates when RECAL_LIMIT consecutive samples drift out.
// Ports:
//   CLK, RST               : clock, synchronous active-high reset
//   START                  : calibration start pulse (honoured in IDLE/FAIL)
//   DATA_IN, DATA_EN_IN    : beat count stream from the TRNG (bits 15:8 unused)
//   RNG_EN, PARAM          : oscillator enable and {16'b0, cfg_a, cfg_b}
//   OUT_DATA/VALID/READY   : random byte port (valid/ready)
//   CALIBRATED, FAIL       : status, high in RUN / FAIL respectively
//   OVERFLOW               : sticky byte-drop flag
//   state_dbg              : current FSM state, for observation only
module coso_calib_ctrl
  import coso_calib_pkg::*;
#(
  parameter int         CNT_MIN     = 16,
  parameter int         CNT_MAX     = 64,
  parameter int         LOG2_NSAMP  = 4,
  parameter int         DISCARD     = 4,
  parameter int         RECAL_LIMIT = 8,
  parameter logic [7:0] INIT_A      = 8'd0,
  parameter logic [7:0] INIT_B      = 8'd0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] DATA_IN,
  input  logic        DATA_EN_IN,
  output logic        RNG_EN,
  output logic [31:0] PARAM,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        CALIBRATED,
  output logic        FAIL,
  output logic        OVERFLOW,
  output coso_state_e state_dbg
);

  localparam int NSAMP   = 1 << LOG2_NSAMP;
  localparam int SMP_MAX = (NSAMP > DISCARD) ? NSAMP : DISCARD;
  localparam int SMP_W   = $clog2(SMP_MAX) + 1;
  localparam int SUM_W   = 8 + LOG2_NSAMP;
  localparam int BAD_W   = $clog2(RECAL_LIMIT) + 1;

  localparam logic [SMP_W-1:0] DISC_LAST  = SMP_W'(DISCARD - 1);
  localparam logic [SMP_W-1:0] NSAMP_LAST = SMP_W'(NSAMP - 1);
  localparam logic [BAD_W-1:0] BAD_LAST   = BAD_W'(RECAL_LIMIT - 1);

  coso_state_e      state, state_n;
  logic [15:0]      cfg;
  logic [SMP_W-1:0] smp_cnt;
  logic [SUM_W-1:0] sum;
  logic [BAD_W-1:0] bad_cnt;

  logic [7:0] cnt;
  logic [7:0] avg;
  logic       cnt_ok, avg_ok, exhausted;
  logic       unused_hi;

  // Control strobes produced by the FSM for the datapath registers.
  logic cfg_init, cfg_adv;
  logic smp_clr, smp_inc;
  logic sum_clr, sum_acc;
  logic bad_clr, bad_inc;
  logic pk_clr, pk_en;

  assign cnt       = DATA_IN[7:0];
  assign unused_hi = ^DATA_IN[15:8];
  assign avg       = 8'(sum >> LOG2_NSAMP);
  assign cnt_ok    = in_window(cnt, CNT_MIN, CNT_MAX);
  assign avg_ok    = in_window(avg, CNT_MIN, CNT_MAX);
  assign exhausted = (cfg == 16'hFFFF);

  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    cfg_init = 1'b0;
    cfg_adv  = 1'b0;
    smp_clr  = 1'b0;
    smp_inc  = 1'b0;
    sum_clr  = 1'b0;
    sum_acc  = 1'b0;
    bad_clr  = 1'b0;
    bad_inc  = 1'b0;
    pk_clr   = 1'b0;
    pk_en    = 1'b0;

    case (state)
      ST_IDLE, ST_FAIL: begin
        if (START) begin
          state_n  = ST_SETTLE;
          cfg_init = 1'b1;
          smp_clr  = 1'b1;
          pk_clr   = 1'b1;
        end
      end

      ST_SETTLE: begin
        if (DATA_EN_IN) begin
          if (smp_cnt == DISC_LAST) begin
            state_n = ST_MEASURE;
            smp_clr = 1'b1;
            sum_clr = 1'b1;
          end else begin
            smp_inc = 1'b1;
          end
        end
      end

      ST_MEASURE: begin
        if (DATA_EN_IN) begin
          sum_acc = 1'b1;
          if (smp_cnt == NSAMP_LAST) begin
            state_n = ST_EVAL;
            smp_clr = 1'b1;
          end else begin
            smp_inc = 1'b1;
          end
        end
      end

      // Single decision cycle; DATA_EN_IN is deliberately not looked at.
      ST_EVAL: begin
        if (avg_ok) begin
          state_n = ST_RUN;
          bad_clr = 1'b1;
        end else if (exhausted) begin
          state_n = ST_FAIL;
        end else begin
          state_n = ST_SETTLE;
          cfg_adv = 1'b1;
          smp_clr = 1'b1;
        end
      end

      ST_RUN: begin
        if (DATA_EN_IN) begin
          if (cnt_ok) begin
            bad_clr = 1'b1;
            pk_en   = 1'b1;
          end else if (bad_cnt == BAD_LAST) begin
            // Drift confirmed: abandon this candidate and any partial byte.
            bad_clr = 1'b1;
            pk_clr  = 1'b1;
            if (exhausted) begin
              state_n = ST_FAIL;
            end else begin
              state_n = ST_SETTLE;
              cfg_adv = 1'b1;
              smp_clr = 1'b1;
            end
          end else begin
            bad_inc = 1'b1;
            pk_en   = 1'b1;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg     <= '0;
      smp_cnt <= '0;
      sum     <= '0;
      bad_cnt <= '0;
    end else begin
      if (cfg_init)     cfg <= {INIT_A, INIT_B};
      else if (cfg_adv) cfg <= cfg + 16'd1;

      if (smp_clr)      smp_cnt <= '0;
      else if (smp_inc) smp_cnt <= smp_cnt + SMP_W'(1);

      // SUM_W is wide enough for NSAMP full-scale counts.
      if (sum_clr)      sum <= '0;
      else if (sum_acc) sum <= sum + SUM_W'(cnt);

      if (bad_clr)      bad_cnt <= '0;
      else if (bad_inc) bad_cnt <= bad_cnt + BAD_W'(1);
    end
  end

  always_comb begin
    PARAM = '0;
    PARAM[CFG_A_LSB +: CFG_W] = cfg[15:8];
    PARAM[CFG_B_LSB +: CFG_W] = cfg[7:0];
  end

  assign RNG_EN     = (state == ST_SETTLE) || (state == ST_MEASURE) ||
                      (state == ST_EVAL)   || (state == ST_RUN);
  assign CALIBRATED = (state == ST_RUN);
  assign FAIL       = (state == ST_FAIL);
  assign state_dbg  = state;

  coso_bit_packer u_packer (
    .clk       (CLK),
    .rst       (RST),
    .bit_in    (cnt[0]),
    .bit_en    (pk_en),
    .clr       (pk_clr),
    .OUT_DATA  (OUT_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OVERFLOW  (OVERFLOW)
  );

endmodule

// File: tb/tb_coso_calib_ctrl.sv
// Bench for coso_calib_ctrl. Two instances share one stimulus stream: dut_a
// uses the default initial configuration, dut_b starts at {8'hFF, 8'hFE}.
// `sel` chooses which instance's outputs are observed.
module tb_coso_calib_ctrl;
  import coso_calib_pkg::*;

  // ---------------- clock / reset block ----------------
  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST = 1'b1;
  logic        START = 1'b0;
  logic [15:0] DATA_IN = '0;
  logic        DATA_EN_IN = 1'b0;
  logic        OUT_READY = 1'b1;

  logic        a_rng_en, a_out_valid, a_cal, a_fail, a_ovf;
  logic [31:0] a_param;
  logic [7:0]  a_out_data;
  coso_state_e a_st;
  logic        b_rng_en, b_out_valid, b_cal, b_fail, b_ovf;
  logic [31:0] b_param;
  logic [7:0]  b_out_data;
  coso_state_e b_st;

  coso_calib_ctrl dut_a (
    .CLK(CLK), .RST(RST), .START(START), .DATA_IN(DATA_IN), .DATA_EN_IN(DATA_EN_IN),
    .RNG_EN(a_rng_en), .PARAM(a_param), .OUT_DATA(a_out_data), .OUT_VALID(a_out_valid),
    .OUT_READY(OUT_READY), .CALIBRATED(a_cal), .FAIL(a_fail), .OVERFLOW(a_ovf),
    .state_dbg(a_st)
  );

  coso_calib_ctrl #(.INIT_A(8'hFF), .INIT_B(8'hFE)) dut_b (
    .CLK(CLK), .RST(RST), .START(START), .DATA_IN(DATA_IN), .DATA_EN_IN(DATA_EN_IN),
    .RNG_EN(b_rng_en), .PARAM(b_param), .OUT_DATA(b_out_data), .OUT_VALID(b_out_valid),
    .OUT_READY(OUT_READY), .CALIBRATED(b_cal), .FAIL(b_fail), .OVERFLOW(b_ovf),
    .state_dbg(b_st)
  );

  logic        sel = 1'b0;
  logic        rng_en, out_valid, cal, fail_o, ovf;
  logic [31:0] param;
  logic [7:0]  out_data;
  coso_state_e st;

  always_comb begin
    rng_en = a_rng_en; out_valid = a_out_valid; cal = a_cal; fail_o = a_fail;
    ovf = a_ovf; param = a_param; out_data = a_out_data; st = a_st;
    if (sel) begin
      rng_en = b_rng_en; out_valid = b_out_valid; cal = b_cal; fail_o = b_fail;
      ovf = b_ovf; param = b_param; out_data = b_out_data; st = b_st;
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_q[$];
  int          hs_count = 0;
  logic [7:0]  last_hs = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // A transfer happens at the next rising edge whenever valid and ready are
  // both high at the falling edge.
  always @(negedge CLK) begin
    if (RST === 1'b0 && out_valid === 1'b1 && OUT_READY === 1'b1) begin
      hs_count++;
      last_hs = out_data;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL hs_unexpected observed=%h expected=none", out_data);
      end else begin
        chk("hs_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- reference model state ----------------
  logic [15:0] cand;
  int          m_nbits;
  logic [7:0]  m_acc;
  int          m_bad;
  logic        m_ovf;
  logic        m_recal;

  function automatic int base_count(input int mode, input logic [15:0] c);
    case (mode)
      0:       return 40;
      1:       return (c[7:0] == 8'd3) ? 40 : 100;
      default: return 200;
    endcase
  endfunction

  function automatic logic win(input int v);
    return (v >= 16) && (v <= 64);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_sample(input logic [7:0] c);
    int gap;
    gap = $urandom_range(0, 2);
    repeat (gap) begin
      DATA_EN_IN = 1'b0;
      DATA_IN    = 16'($urandom);
      step();
    end
    DATA_EN_IN = 1'b1;
    DATA_IN    = {8'($urandom), c};
    step();
    DATA_EN_IN = 1'b0;
    DATA_IN    = 16'($urandom);
  endtask

  task automatic push_bit(input logic b);
    m_acc = {m_acc[6:0], b};
    m_nbits++;
    if (m_nbits == 8) begin
      m_nbits = 0;
      if (!OUT_READY && exp_q.size() > 0) m_ovf = 1'b1;
      else                                exp_q.push_back(m_acc);
    end
  endtask

  // One RUN-state sample: harvest a bit or count drift.
  task automatic run_sample(input logic [7:0] c);
    send_sample(c);
    m_recal = 1'b0;
    if (win(int'(c))) begin
      m_bad = 0;
      push_bit(c[0]);
    end else begin
      m_bad++;
      if (m_bad == 8) begin
        m_bad   = 0;
        m_nbits = 0;
        m_recal = 1'b1;
      end else begin
        push_bit(c[0]);
      end
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    repeat (2) begin
      START      = 1'($urandom);
      DATA_IN    = 16'($urandom);
      DATA_EN_IN = 1'($urandom);
      OUT_READY  = 1'($urandom);
      step();
    end
    RST = 1'b0; START = 1'b0; DATA_EN_IN = 1'b0; OUT_READY = 1'b1;
    exp_q.delete();
    m_nbits = 0; m_acc = '0; m_bad = 0; m_ovf = 1'b0; m_recal = 1'b0;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    step();
    START = 1'b0;
  endtask

  // Evaluate candidates from `cand` upward until lock or exhaustion.
  task automatic sweep(input int mode, output logic locked);
    int         base, sum, avg;
    logic [7:0] v;
    locked = 1'b0;
    for (int it = 0; it < 16; it++) begin
      chk("sweep_param", param, {16'h0, cand});
      chk("sweep_rng_en", 32'(rng_en), 32'd1);
      base = base_count(mode, cand);
      // Discarded samples are far from the base so counting them would skew the average.
      repeat (4) send_sample(8'(255 - base));
      sum = 0;
      repeat (16) begin
        v = 8'(base - 10 + int'($urandom_range(0, 20)));
        sum += int'(v);
        send_sample(v);
      end
      avg = sum / 16;
      chk("eval_cal_low", 32'(cal), 32'd0);
      chk("eval_rng_en", 32'(rng_en), 32'd1);
      // Strobe during the decision cycle; it must not be consumed.
      DATA_EN_IN = 1'b1;
      DATA_IN    = 16'h00FF;
      step();
      DATA_EN_IN = 1'b0;
      if (win(avg)) begin
        chk("lock_cal", 32'(cal), 32'd1);
        chk("lock_fail", 32'(fail_o), 32'd0);
        chk("lock_param", param, {16'h0, cand});
        locked = 1'b1;
        return;
      end
      chk("reject_cal", 32'(cal), 32'd0);
      if (cand == 16'hFFFF) begin
        chk("exhaust_fail", 32'(fail_o), 32'd1);
        chk("exhaust_rng_en", 32'(rng_en), 32'd0);
        chk("exhaust_param", param, 32'h0000_FFFF);
        return;
      end
      cand = cand + 16'd1;
      chk("reject_state", 32'(st), 32'(ST_SETTLE));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic locked;
    int   hs0;
    logic [7:0] held;

    // 1. reset with random inputs
    do_reset();
    chk("rst_rng_en", 32'(rng_en), 32'd0);
    chk("rst_param", param, 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_cal", 32'(cal), 32'd0);
    chk("rst_fail", 32'(fail_o), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_state", 32'(st), 32'(ST_IDLE));

    // 2. immediate lock at the initial configuration
    cand = 16'h0000;
    pulse_start();
    sweep(0, locked);
    chk("t2_locked", 32'(locked), 32'd1);
    START = 1'b1; step(); START = 1'b0;  // ignored in RUN
    chk("run_start_ignored_cal", 32'(cal), 32'd1);
    chk("run_start_ignored_param", param, 32'd0);

    // 3. sweep: only cfg_b==3 gives in-window counts
    do_reset();
    cand = 16'h0000;
    pulse_start();
    sweep(1, locked);
    chk("t3_locked", 32'(locked), 32'd1);
    chk("t3_param", param, 32'h0000_0003);
    chk("t3_fail", 32'(fail_o), 32'd0);

    // 4. packing with OUT_READY=1
    OUT_READY = 1'b1;
    hs0 = hs_count;
    run_sample(8'd41); run_sample(8'd40); run_sample(8'd41); run_sample(8'd41);
    run_sample(8'd40); run_sample(8'd40); run_sample(8'd41); run_sample(8'd40);
    step();
    chk("t4_hs_count", 32'(hs_count - hs0), 32'd1);
    chk("t4_byte", 32'(last_hs), 32'h0000_00B2);
    chk("t4_valid_cleared", 32'(out_valid), 32'd0);

    // random in-window bytes
    repeat (24) run_sample(8'($urandom_range(16, 64)));
    step();
    chk("rand_bytes_drained", 32'(exp_q.size()), 32'd0);

    // window boundaries: 15/65 are out, 16/64 are in and reset the drift count
    for (int i = 0; i < 7; i++) run_sample((i % 2 == 0) ? 8'd15 : 8'd65);
    run_sample(8'd16);
    repeat (7) run_sample(8'd65);
    run_sample(8'd64);
    chk("bound_cal", 32'(cal), 32'd1);
    chk("bound_param", param, 32'h0000_0003);
    step();

    // 5. backpressure
    OUT_READY = 1'b0;
    step();
    hs0 = hs_count;
    repeat (16) begin
      run_sample(8'($urandom_range(16, 64)));
      if (exp_q.size() > 0) begin
        held = exp_q[0];
        chk("bp_valid", 32'(out_valid), 32'd1);
        chk("bp_held_data", 32'(out_data), 32'(held));
      end
    end
    chk("bp_ovf", 32'(ovf), 32'(m_ovf));
    chk("bp_ovf_set", 32'(ovf), 32'd1);
    OUT_READY = 1'b1;
    step();
    step();
    chk("bp_one_hs", 32'(hs_count - hs0), 32'd1);
    chk("bp_valid_cleared", 32'(out_valid), 32'd0);
    chk("bp_ovf_sticky", 32'(ovf), 32'd1);

    do_reset();
    chk("ovf_cleared_by_rst", 32'(ovf), 32'd0);

    // 6. recalibration and exhaustion on the high-start instance
    sel = 1'b1;
    do_reset();
    cand = 16'hFFFE;
    pulse_start();
    sweep(0, locked);
    chk("t6_locked", 32'(locked), 32'd1);
    run_sample(8'd40);
    repeat (7) begin
      run_sample(8'd200);
      chk("t6_still_cal", 32'(cal), 32'd1);
    end
    run_sample(8'd200);
    chk("t6_recal_model", 32'(m_recal), 32'd1);
    cand = cand + 16'd1;
    chk("t6_recal_cal", 32'(cal), 32'd0);
    chk("t6_recal_param", param, 32'h0000_FFFF);
    chk("t6_recal_state", 32'(st), 32'(ST_SETTLE));
    step();
    chk("t6_byte_drained", 32'(exp_q.size()), 32'd0);
    sweep(2, locked);
    chk("t6_not_locked", 32'(locked), 32'd0);
    chk("t6_fail_state", 32'(st), 32'(ST_FAIL));
    pulse_start();
    cand = 16'hFFFE;
    chk("t6_restart_param", param, {16'h0, cand});
    chk("t6_restart_fail", 32'(fail_o), 32'd0);
    chk("t6_restart_rng_en", 32'(rng_en), 32'd1);
    chk("t6_restart_state", 32'(st), 32'(ST_SETTLE));

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/coso_calib_ctrl.md
Name: coso_calib_ctrl

Overview:
- Closed-loop controller for the configurable COSO TRNG unit.
- Drives the unit's RNG_EN and PARAM, and consumes its beat-count stream (DATA_OUT/DATA_EN).
- Sweeps the two ring-oscillator delay configurations until the averaged beat count falls inside a target window, then harvests count LSBs as random bits.
- Packs harvested bits into bytes on a valid/ready port and recalibrates automatically when counts drift out of the window.

Parameters:
- CNT_MIN, 16: inclusive lower bound of the acceptable beat count.
- CNT_MAX, 64: inclusive upper bound of the acceptable beat count.
- LOG2_NSAMP, 4: log2 of the number of samples averaged per evaluation (16 samples).
- DISCARD, 4: samples dropped after every configuration change or enable.
- RECAL_LIMIT, 8: consecutive out-of-window samples in RUN that trigger recalibration.
- INIT_A, 8'd0: initial configuration for oscillator A.
- INIT_B, 8'd0: initial configuration for oscillator B.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous reset, active-high.
- START  in  1  one-cycle pulse; starts calibration. Honoured only in IDLE or FAIL.
- DATA_IN  in  16  beat count from the TRNG unit. Bits 15:8 are ignored.
- DATA_EN_IN  in  1  count-valid strobe from the TRNG unit.
- RNG_EN  out  1  oscillator enable to the TRNG unit.
- PARAM  out  32  bits 15:8 = cfg_a, bits 7:0 = cfg_b, bits 31:16 = 0.
- OUT_DATA  out  8  packed random byte.
- OUT_VALID  out  1  OUT_DATA is valid.
- OUT_READY  in  1  downstream accepts OUT_DATA.
- CALIBRATED  out  1  high while in RUN.
- FAIL  out  1  high while in FAIL.
- OVERFLOW  out  1  sticky; set when a completed byte is dropped.

Behaviour:
- Single clock domain, CLK. RST is synchronous, active-high.
- Reset values: RNG_EN=0, PARAM=0, OUT_DATA=0, OUT_VALID=0, CALIBRATED=0, FAIL=0, OVERFLOW=0, state=IDLE. Reset mid-operation aborts everything, including any pending byte.
- A sample is counted only in a cycle where DATA_EN_IN=1. cnt = DATA_IN[7:0].
- In window means CNT_MIN <= value <= CNT_MAX (both bounds inclusive).
- IDLE: RNG_EN=0. On START: load cfg={INIT_A,INIT_B}, clear the packer, go to SETTLE.
- SETTLE: RNG_EN=1. After DISCARD samples, clear the accumulator and go to MEASURE.
- MEASURE:
  - sum += cnt. sum width is 8+LOG2_NSAMP, so it cannot overflow.
  - After 2^LOG2_NSAMP samples, go to EVAL.
- EVAL: lasts one cycle; any DATA_EN_IN in this cycle is ignored. avg = sum >> LOG2_NSAMP.
  - If avg is in window, go to RUN. CALIBRATED rises in the following cycle.
  - Otherwise advance the candidate.
- Advance candidate:
  - The candidate is the 16-bit value {cfg_a,cfg_b}; increment it by 1 (cfg_b carries into cfg_a).
  - If {cfg_a,cfg_b}==16'hFFFF before the increment, the sweep is exhausted: go to FAIL.
  - Otherwise PARAM updates next cycle and the state returns to SETTLE.
- RUN:
  - Each sample shifts cnt[0] into the packer, first bit into the MSB.
  - Consecutive out-of-window samples are counted. Any in-window sample resets the count to 0.
  - When the count reaches RECAL_LIMIT: CALIBRATED=0, advance candidate (including the FAIL check), drop any partial bits. An already-valid byte is kept.
- FAIL:
  - RNG_EN=0. PARAM holds the last candidate tried.
  - START restarts from INIT_A/INIT_B, clears FAIL and goes to SETTLE.
- START in any other state is ignored.
- Packer:
  - After 8 bits, the byte loads OUT_DATA and OUT_VALID=1 next cycle.
  - OUT_VALID stays high and OUT_DATA stays stable until a cycle with OUT_READY=1, which clears OUT_VALID.
  - If an 8th bit completes while OUT_VALID=1 and OUT_READY=0, the new byte is dropped and OVERFLOW is set.
  - If an 8th bit completes in the same cycle as a handshake, the new byte is loaded and OUT_VALID stays 1, with no overflow.
- OVERFLOW is cleared only by RST.

Decomposition:
- Package coso_calib_pkg contains:
  - the state enum (IDLE, SETTLE, MEASURE, EVAL, RUN, FAIL);
  - PARAM field positions CFG_A_LSB=8, CFG_B_LSB=0, CFG_W=8.
- One sub-module, coso_bit_packer, holds the bit shift register, bit counter, valid/ready output register and OVERFLOW. Interface: bit_in, bit_en, clr, OUT_*.

Test Plan:
1. Reset: RST high for 2 cycles with random inputs -> RNG_EN=0, PARAM=0, OUT_VALID=0, CALIBRATED=0, FAIL=0, OVERFLOW=0.
2. Immediate lock: behavioral model returns 40 for every configuration; pulse START -> 4 samples discarded, 16 measured, CALIBRATED=1 two cycles after the 20th DATA_EN_IN, PARAM=32'h0000_0000, RNG_EN=1 throughout.
3. Sweep: model returns 100 unless cfg_b==3, otherwise 40 -> configurations 0,1,2 rejected; lock with PARAM=32'h0000_0003, no FAIL.
4. Packing: in RUN, OUT_READY=1, feed counts 41,40,41,41,40,40,41,40 -> exactly one OUT_VALID pulse with OUT_DATA=8'hB2.
5. Backpressure: in RUN, OUT_READY=0, 16 in-window samples -> first byte held stable, second byte dropped, OVERFLOW=1. Raising OUT_READY completes one handshake; OVERFLOW stays 1.
6. Recalibration and fail: INIT_A=8'hFF, INIT_B=8'hFE, model returns 40, lock reached; then model returns 200 for 8 samples -> CALIBRATED=0, PARAM=32'h0000_FFFF, state SETTLE. That configuration is also rejected -> FAIL=1, RNG_EN=0. START restarts the sweep at 32'h0000_FFFE.
